// File: rtl/bs_sched_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
// Holds the FSM state encoding and the packet header field extractor.
package bs_sched_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
    localparam int PKT_MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2,
        PUSH   = 2'd3
    } sched_state_t;

    // The packet must be left-justified so the destination ID sits in the top bits.
    function automatic logic [ID_W-1:0] id_field(input logic [PKT_MAX_W-1:0] pkt);
        return pkt[PKT_MAX_W-1 -: ID_W];
    endfunction

endpackage

// File: rtl/bs_rr_scheduler_if.sv
// Bus between the scheduler and the terminal FIFO array.
// The scheduler is the master: it samples pending/head words and drives the strobes.
interface bs_rr_scheduler_if #(
    parameter int drvrs   = 8,
    parameter int pckg_sz = 32
);

    logic [drvrs-1:0]              pndng;
    logic [drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]              pop;
    logic [drvrs-1:0]              push;
    logic [drvrs-1:0][pckg_sz-1:0] D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );

endinterface

// File: rtl/bs_rr_picker.sv
// Combinational rotating-priority picker: the first requester after 'last' wins, with wrap.
// Rotates the request vector, priority-encodes, then maps the offset back to a terminal index.
module bs_rr_picker #(
    parameter  int drvrs = 8,
    localparam int IDX_W = $clog2(drvrs)
) (
    input  logic [drvrs-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [drvrs-1:0] rot_s;
    logic [IDX_W-1:0] off_s;
    int               j_s;
    int               k_s;

    // Bit 0 of rot_s is the terminal right after 'last'; the lowest set bit is the winner.
    always_comb begin
        rot_s = '0;
        off_s = '0;
        j_s   = 0;
        k_s   = 0;
        for (int i = 0; i < drvrs; i++) begin
            j_s      = int'(last) + 1 + i;
            j_s      = (j_s >= drvrs) ? (j_s - drvrs) : j_s;
            rot_s[i] = req[IDX_W'(j_s)];
        end
        for (int i = drvrs - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? IDX_W'(i) : off_s;
        end
        k_s     = int'(last) + 1 + int'(off_s);
        k_s     = (k_s >= drvrs) ? (k_s - drvrs) : k_s;
        gnt_idx = IDX_W'(k_s);
        any     = |req;
    end

endmodule

// File: rtl/bs_rr_scheduler.sv
// Round-robin transaction scheduler: pops one head word per transaction and routes it
// by its header ID to one terminal, or to every other terminal on broadcast.
module bs_rr_scheduler
    import bs_sched_pkg::*;
#(
    parameter  int              pckg_sz   = 32,
    parameter  int              drvrs     = 8,
    parameter  logic [ID_W-1:0] broadcast = BROADCAST_ID,
    localparam int              IDX_W     = $clog2(drvrs)
) (
    input  logic                     clk,
    input  logic                     reset,
    bs_rr_scheduler_if.master        bus,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     busy,
    output logic                     err_bad_id,
    output logic [15:0]              pkt_cnt
);

    localparam logic [drvrs-1:0] LANE0 = {{(drvrs-1){1'b0}}, 1'b1};

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [pckg_sz-1:0] data_q, data_d;
    logic [pckg_sz-1:0] dpush_q, dpush_d;
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [IDX_W-1:0]   pick_s;
    logic               any_s;
    logic [ID_W-1:0]    dest_s;
    logic [drvrs-1:0]   mask_s;
    logic               bad_s;

    bs_rr_picker #(.drvrs(drvrs)) u_picker (
        .req     (bus.pndng),
        .last    (last_q),
        .gnt_idx (pick_s),
        .any     (any_s)
    );

    // Destination mask: broadcast skips the source, in-range IDs hit one lane, anything else drops.
    always_comb begin
        dest_s = id_field(PKT_MAX_W'(data_q) << (PKT_MAX_W - pckg_sz));
        if (dest_s == broadcast) begin
            mask_s = ~(LANE0 << grant_q);
            bad_s  = 1'b0;
        end else if (dest_s < ID_W'(drvrs)) begin
            mask_s = LANE0 << dest_s;
            bad_s  = 1'b0;
        end else begin
            mask_s = '0;
            bad_s  = 1'b1;
        end
    end

    // Next-state and next-output logic; strobes default low so each lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        dpush_d = dpush_q;
        pop_d   = '0;
        push_d  = '0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    grant_d = pick_s;
                    pop_d   = LANE0 << pick_s;
                    state_d = POP;
                end else begin
                    state_d = IDLE;
                end
            end
            POP: begin
                data_d  = bus.D_pop[grant_q];
                last_d  = grant_q;
                state_d = DECODE;
            end
            DECODE: begin
                push_d  = mask_s;
                dpush_d = data_q;
                err_d   = bad_s;
                state_d = PUSH;
            end
            PUSH: begin
                if ((push_q != '0) && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Scheduler state and registered outputs; reset abandons any in-flight packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(drvrs - 1);
            data_q  <= '0;
            dpush_q <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            dpush_q <= dpush_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pop    = pop_q;
    assign bus.push   = push_q;
    assign bus.D_push = {drvrs{dpush_q}};
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign err_bad_id = err_q;
    assign pkt_cnt    = cnt_q;

endmodule
